// File: rtl/irq_sched.sv
// rtl/irq_sched.sv - interrupt scheduler: masked fixed-priority requests, safe-slot injection, no nesting, post-return hold-off
module irq_sched #(
    parameter int NSRC    = 4,
    parameter int HOLDOFF = 3,
    localparam int CW     = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic            kernel_in,
    input  logic            flush_in,
    input  logic            stall_in,
    input  logic [31:0]     id_pc,
    input  logic            eret_in,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    output logic            take_irq,
    output logic [CW-1:0]   irq_cause,
    output logic [31:0]     epc,
    output logic [NSRC-1:0] irq_mask,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INJECT,
        S_IN_HANDLER
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_holdoff;
    logic            r_take;
    logic            r_busy;
    logic [CW-1:0]   r_cause;
    logic [31:0]     r_epc;
    logic [NSRC-1:0] r_mask;

    logic [NSRC-1:0] w_req;
    logic [CW-1:0]   w_winner;
    logic            w_safe;
    logic            w_go;
    logic            w_ret;

    // Descending scan so the lowest set index wins.
    always_comb begin
        w_req    = irq_in & r_mask;
        w_winner = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_winner = CW'(i);
            end
        end
    end

    assign w_safe = ~flush_in & ~stall_in & ~kernel_in & (r_holdoff == 4'd0);

    always_comb begin
        w_next = r_state;
        w_go   = 1'b0;
        w_ret  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((|w_req) && w_safe) begin
                    w_next = S_INJECT;
                    w_go   = 1'b1;
                end
            end
            S_INJECT: begin
                w_next = S_IN_HANDLER;
            end
            S_IN_HANDLER: begin
                if (eret_in) begin
                    w_next = S_IDLE;
                    w_ret  = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Take and busy are registered from the next state so Control sees clean levels.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_take    <= 1'b0;
            r_busy    <= 1'b0;
            r_cause   <= '0;
            r_epc     <= 32'd0;
            r_mask    <= '1;
            r_holdoff <= 4'd0;
        end else begin
            r_take <= w_go;
            r_busy <= (w_next != S_IDLE);
            if (w_go) begin
                r_cause <= w_winner;
                r_epc   <= id_pc;
            end
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
            if (w_ret) begin
                r_holdoff <= 4'(HOLDOFF);
            end else if (r_holdoff != 4'd0) begin
                r_holdoff <= r_holdoff - 4'd1;
            end
        end
    end

    assign take_irq  = r_take;
    assign busy      = r_busy;
    assign irq_cause = r_cause;
    assign epc       = r_epc;
    assign irq_mask  = r_mask;

endmodule

// File: tb/tb_irq_sched.sv
// tb/tb_irq_sched.sv - scoreboard bench for irq_sched with a rule-level reference model
module tb_irq_sched;

    localparam int NSRC    = 4;
    localparam int HOLDOFF = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NSRC-1:0] irq_in = '0;
    logic            kernel_in = 1'b0;
    logic            flush_in = 1'b0;
    logic            stall_in = 1'b0;
    logic [31:0]     id_pc = 32'd0;
    logic            eret_in = 1'b0;
    logic            mask_we = 1'b0;
    logic [NSRC-1:0] mask_wdata = '0;
    logic            take_irq;
    logic [1:0]      irq_cause;
    logic [31:0]     epc;
    logic [NSRC-1:0] irq_mask;
    logic            busy;

    irq_sched #(.NSRC(NSRC), .HOLDOFF(HOLDOFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .kernel_in (kernel_in),
        .flush_in  (flush_in),
        .stall_in  (stall_in),
        .id_pc     (id_pc),
        .eret_in   (eret_in),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .take_irq  (take_irq),
        .irq_cause (irq_cause),
        .epc       (epc),
        .irq_mask  (irq_mask),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Expected injections: {cause, epc}
    logic [33:0] sb[$];

    // Reference model: 0 = waiting, 1 = injecting, 2 = handler running
    int          m_phase = 0;
    int          m_hold  = 0;
    logic [3:0]  m_mask  = 4'hF;
    logic [1:0]  m_cause = 2'd0;
    logic [31:0] m_epc   = 32'd0;

    function automatic int lowest_set(input logic [3:0] v);
        for (int i = 0; i < NSRC; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            m_phase = 0;
            m_hold  = 0;
            m_mask  = 4'hF;
            m_cause = 2'd0;
            m_epc   = 32'd0;
            sb.delete();
        end else begin
            int win;
            bit returning;
            win       = lowest_set(irq_in & m_mask);
            returning = 1'b0;
            if (m_phase == 0) begin
                if (win >= 0 && !flush_in && !stall_in && !kernel_in && m_hold == 0) begin
                    m_phase = 1;
                    m_cause = 2'(win);
                    m_epc   = id_pc;
                    sb.push_back({m_cause, m_epc});
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (eret_in) begin
                m_phase   = 0;
                returning = 1'b1;
            end
            if (returning) m_hold = HOLDOFF;
            else if (m_hold > 0) m_hold = m_hold - 1;
            if (mask_we) m_mask = mask_wdata;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("take_irq", 32'(take_irq), 32'(m_phase == 1));
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("irq_mask", 32'(irq_mask), 32'(m_mask));
            check("irq_cause_hold", 32'(irq_cause), 32'(m_cause));
            check("epc_hold", epc, m_epc);
            if (take_irq === 1'b1) begin
                if (sb.size() == 0) begin
                    check("take_unexpected", 32'(take_irq), 32'd0);
                end else begin
                    logic [33:0] e;
                    e = sb.pop_front();
                    check("sb_cause", 32'(irq_cause), 32'(e[33:32]));
                    check("sb_epc", epc, e[31:0]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_eret();
        eret_in = 1'b1;
        step(1);
        eret_in = 1'b0;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        step(1);
        mask_we    = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        step(2);
        mon_en = 1'b1;
        reset  = 1'b1;
        step(1);

        // Basic take
        irq_in = 4'b0100; id_pc = 32'h40;
        step(3);
        irq_in = 4'b0000;
        pulse_eret();
        step(6);

        // Priority and mask
        irq_in = 4'b1010; id_pc = 32'h100;
        step(2);
        irq_in = 4'b0000;
        pulse_eret();
        step(5);
        write_mask(4'b1101);
        irq_in = 4'b1010; id_pc = 32'h104;
        step(2);
        irq_in = 4'b0000;
        pulse_eret();
        step(5);
        write_mask(4'b0000);
        irq_in = 4'b1111;
        step(20);
        irq_in = 4'b0000;
        write_mask(4'b1111);

        // Unsafe slots then first safe cycle
        irq_in = 4'b0001; flush_in = 1'b1; id_pc = 32'h200;
        step(2);
        flush_in = 1'b0; stall_in = 1'b1; id_pc = 32'h204;
        step(1);
        stall_in = 1'b0; kernel_in = 1'b1; id_pc = 32'h8000_0000;
        step(5);
        kernel_in = 1'b0; id_pc = 32'h208;
        step(1);
        id_pc = 32'h20C;
        // No nesting, then return with request still high: hold-off applies
        step(4);
        pulse_eret();
        step(8);
        irq_in = 4'b0000;
        pulse_eret();
        step(5);

        // Spurious eret in idle with a new request: no hold-off
        irq_in = 4'b0100; eret_in = 1'b1; id_pc = 32'h300;
        step(1);
        eret_in = 1'b0; irq_in = 4'b0000;
        step(2);
        pulse_eret();
        step(5);

        // Mask write in the same cycle as a safe take
        irq_in = 4'b0010; mask_we = 1'b1; mask_wdata = 4'b0000; id_pc = 32'h400;
        step(1);
        mask_we = 1'b0; irq_in = 4'b0000;
        step(2);
        pulse_eret();
        step(5);
        write_mask(4'b1111);

        // Reset during INJECT
        irq_in = 4'b0001; id_pc = 32'h500;
        step(1);
        reset = 1'b0;
        step(1);
        reset = 1'b1; irq_in = 4'b0000;
        step(3);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            irq_in     = 4'($urandom);
            flush_in   = ($urandom_range(0, 3) == 0);
            stall_in   = ($urandom_range(0, 5) == 0);
            kernel_in  = ($urandom_range(0, 4) == 0);
            id_pc      = $urandom;
            eret_in    = ($urandom_range(0, 3) == 0);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 4'($urandom);
            reset      = ($urandom_range(0, 199) != 0);
            step(1);
        end
        reset = 1'b1; mask_we = 1'b0; eret_in = 1'b0; irq_in = 4'b0000;
        step(3);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_sched.md
Name: irq_sched

Overview:
- Interrupt scheduler for the 5-stage pipelined CPU. Collects level requests from peripherals (timer, UART rx/tx) and applies a mask register and fixed priority.
- Picks a safe pipeline slot: no flush, no load-use stall, user mode. In that slot it issues a one-cycle inject pulse that Control uses to replace the ID-stage instruction with the interrupt jump.
- Captures EPC and cause, blocks nesting until the handler returns, then enforces a hold-off so user code makes forward progress.

Parameters:
- NSRC, 4, number of interrupt sources; index 0 has the highest priority.
- HOLDOFF, 3, cycles after handler return during which no new interrupt is injected; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- irq_in  in  NSRC  level requests from peripherals
- kernel_in  in  1  supervisor bit of the ID-stage PC (PC4[31])
- flush_in  in  1  branch, jump, jr or exception flush in the current cycle
- stall_in  in  1  load-use stall in the current cycle
- id_pc  in  32  PC of the instruction currently in ID
- eret_in  in  1  one-cycle pulse: jr $26 executed in ID with a target in user space
- mask_we  in  1  mask register write strobe from the peripheral bus
- mask_wdata  in  NSRC  new mask value; 1 = enabled
- take_irq  out  1  one-cycle inject pulse to Control
- irq_cause  out  clog2(NSRC) (min 1)  index of the source being serviced
- epc  out  32  return address, i.e. the ID-stage PC at the moment of injection
- irq_mask  out  NSRC  current mask
- busy  out  1  high while in the handler (INJECT or IN_HANDLER)

Behaviour:
- Reset (reset==0 at a clk edge) sets:
  - state = IDLE
  - take_irq = 0, irq_cause = 0, epc = 0
  - irq_mask = all ones
  - busy = 0, hold-off counter = 0
- Request path:
  - req = irq_in & irq_mask, evaluated combinationally each cycle.
  - Winner = lowest set index of req.
  - Sources are not latched: a request that drops before injection is lost, by design. Peripherals hold their IRQ level until software clears it.
- mask_we: irq_mask <= mask_wdata on the next edge, in any state. A mask write in the same cycle as a safe slot does not affect that cycle's decision, which uses the old mask.
- Safe slot: safe = ~flush_in & ~stall_in & ~kernel_in & (holdoff_cnt==0).
- States and transitions:
  - IDLE: if req!=0 and safe, go to INJECT. take_irq is registered and is high for exactly the one cycle in INJECT. irq_cause <= winner and epc <= id_pc are captured on the same edge. If req!=0 and not safe, stay in IDLE and re-evaluate every cycle; winner and epc are re-sampled at the actual take.
  - INJECT (1 cycle): take_irq = 1, busy = 1, then go to IN_HANDLER unconditionally. flush_in or stall_in during INJECT is ignored; Control gives take_irq priority over the stall.
  - IN_HANDLER: busy = 1, take_irq = 0, requests are ignored (no nesting). On eret_in: go to IDLE and load holdoff_cnt <= HOLDOFF.
- Hold-off:
  - holdoff_cnt decrements by 1 each cycle while nonzero and saturates at 0.
  - No injection while it is nonzero, whatever req is.
- eret_in outside IN_HANDLER is ignored: no state change and no hold-off load.
- Simultaneous eret_in and a new request: the return is taken first. The new request waits at least HOLDOFF cycles after return.
- Reset mid-operation (any state) takes effect on the next edge and drops a pending take_irq.
- epc and irq_cause hold their values until the next injection; they are readable by the handler via the peripheral bus.
- Latency: with a stable request and safe conditions, take_irq rises 1 cycle after irq_in rises, because req is sampled at edge N and take_irq is high during cycle N+1.

Test Plan:
- Basic take: reset, irq_in=4'b0100, safe, id_pc=0x00000040 → take_irq high 1 cycle after the request; irq_cause=2, epc=0x40, busy=1; take_irq low in the following cycle.
- Priority and mask:
  - irq_in=4'b1010 → irq_cause=1.
  - Repeat after writing mask=4'b1101 → irq_cause=3.
  - With mask=4'b0000 → no take_irq for 20 cycles.
- Unsafe slots: request held while flush_in=1 (2 cycles), then stall_in=1 (1 cycle), then kernel_in=1 (5 cycles) → no take_irq. Injection occurs in the first cycle with all three low; epc equals the id_pc of that cycle.
- No nesting and hold-off: in IN_HANDLER, assert irq_in=4'b0001 → no take. Pulse eret_in with the request still high → take_irq reasserts exactly HOLDOFF+1=4 cycles after eret_in.
- Spurious and simultaneous: eret_in in IDLE → no hold-off (next take after 1 cycle). mask_we in the same cycle as a safe take → old mask decides, new mask visible on irq_mask the next cycle.
- Reset during INJECT: drive reset=0 while take_irq=1 → next edge: take_irq=0, busy=0, epc=0, irq_mask=4'b1111, state IDLE.
